ether_rx: RTL
=============

// Module: ether_rx
// PURPOSE
//  MII receive MAC, the receive-side counterpart of ether_tx. Strips preamble/SFD, packs nibbles LSB-first into
//  32-bit words and writes them into a single-frame buffer (memory, 512x32). Checks the FCS and the length rules.
//  The host drains the frame through a cs/cmd/toggle-ready port. This port works the same way as the ether_tx host port.
// PARAMETERS
//  MIN_BYTES  64    smallest legal frame, DA..FCS inclusive; a shorter frame sets RUNT
//  MAX_BYTES  1522  largest legal frame; reaching MAX_BYTES+1 aborts the frame (drop, no buffer update)
//  IFG_NIB    24    erx_dv must stay low for this many nibbles before a new preamble is accepted
// PORTS
//  erx_clk    in   1   MII RX clock; all logic on posedge
//  erx_rst_n  in   1   asynchronous reset, active low
//  erx_rxd    in   4   MII receive nibble
//  erx_dv     in   1   MII receive data valid
//  erx_er     in   1   MII receive error
//  erx_cs     in   1   host command strobe (level)
//  erx_cmd    in   4   host command: 1 GETSIZE, 2 GETDATA, 3 RELEASE, 5 GETSTAT
//  erx_data   out  32  host read data, valid when erx_ready toggles
//  erx_ready  out  1   toggles once per completed host command
//  erx_frame  out  1   1 = a received frame is held in the buffer
//  erx_debug  out  8   {state[3:0], drop_cnt[3:0]}
// BEHAVIOUR
//  Reset values: erx_data=0, erx_ready=0, erx_frame=0, erx_debug=0, all counters 0, rx FSM IDLE, host FSM HIDLE.
//  Reset mid-frame discards the partial frame. No memory write occurs after erx_rst_n falls.
//  RX FSM:
//  - IDLE: erx_dv must have been low for >= IFG_NIB nibbles. Then erx_dv=1 && rxd=4'b0101 goes to PREAMBLE.
//  - PREAMBLE: rxd=0101 stays in PREAMBLE. rxd=1101 goes to DATA with crc=FFFFFFFF, nib=0. Any other nibble, or dv=0, returns to IDLE silently.
//  - DATA: each nibble goes into word[4*nib[2:0] +: 4]. The crc is updated over the 4 bits, bit0 first:
//    fb = crc[31]^b; crc = {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
//    On nib[2:0]==7 the word is written to addr nib[11:3] on the next cycle.
//  - DATA ends on dv=0. The held partial word is written with zero-padded upper nibbles. byte count = nib>>1.
//    Then to DONE.
//  - DONE: sets status and erx_frame=1. Status bits: CRCERR (crc != 32'hC704DD7B), RUNT, ALIGN (nib odd), RXERR (erx_er seen in DATA).
//    Then to IDLE.
//  - Overflow: count reaching MAX_BYTES+1 goes to DISCARD. DISCARD waits for dv=0, then drop_cnt++.
//  - Frame arriving while erx_frame=1: preamble ignored, drop_cnt++ once per dv rising edge. The buffer is untouched.
//  - drop_cnt is 8 bits and saturates at FF.
//  Host FSM, separate from the RX FSM:
//  - HIDLE accepts a command only while erx_cs=1. The command completes, then erx_ready toggles exactly once.
//  - After completion the FSM waits in HWAIT until erx_cs=0 before accepting the next command.
//  - GETSIZE (1 cycle): erx_data = {status[3:0], 17'b0, bytes[10:0]} and rd_ptr=0. Returns bytes=0 if erx_frame=0.
//  - GETDATA: mem read at rd_ptr; erx_data = word 2 cycles later; rd_ptr++ (9 bits, wraps at 512).
//    If erx_frame=0 it returns 0 with no read.
//  - RELEASE: erx_frame=0 and rd_ptr=0. The RX FSM may accept the next preamble on the following cycle.
//  - GETSTAT (1 cycle): erx_data = {24'b0, drop_cnt}.
//  - Unknown cmd: ready still toggles and erx_data is unchanged.
//  Memory ownership: RX writes only while erx_frame=0; host reads only while erx_frame=1. No arbitration is needed.
//  Simultaneous RELEASE and dv rising in the same cycle: that frame counts as dropped.
// STRUCTURE
//  ether_pkg: ERX_CMD_* codes, CRC_POLY 32'h04C11DB7, CRC_RESIDUE 32'hC704DD7B, CRC_INIT, RX/host state encodings, status bit indices.
//  Sub-modules:
//  - existing memory (512x32, sync read, toggle-enable), instantiated as memory_rx.
//  - erx_crc32_nib: 4-bit-per-cycle CRC step, combinational, shared with testbench.
// TESTING
//  1. 64-byte frame with 7x0101+1101 preamble/SFD and correct FCS, then GETSIZE.
//     -> erx_data=32'h00000040. GETDATA x16 returns packed words in order. Status=0.
//  2. Same frame with one payload nibble flipped. -> CRCERR set (erx_data[31:28]=4'b1000), bytes=64.
//  3. 60-byte good-CRC frame. -> RUNT set. 61.5-byte frame (123 nibbles). -> ALIGN set, last word zero-padded.
//  4. Frame 1 received; frame 2 sent before RELEASE. -> frame 1 data intact, GETSTAT=1.
//     After RELEASE, frame 3 is received normally.
//  5. 1600-byte frame. -> no erx_frame, GETSTAT increments. Next legal frame is received. erx_rst_n pulsed mid-frame.
//     -> outputs at reset values, next frame received cleanly.
//  6. Host holds erx_cs high for 10 cycles with GETDATA. -> exactly one ready toggle, rd_ptr advances by 1.

Source files
------------

// File: rtl/ether_pkg.sv
// Shared constants and state encodings for the MII receive MAC.
package ether_pkg;

    localparam logic [3:0] ERX_CMD_GETSIZE = 4'd1;
    localparam logic [3:0] ERX_CMD_GETDATA = 4'd2;
    localparam logic [3:0] ERX_CMD_RELEASE = 4'd3;
    localparam logic [3:0] ERX_CMD_GETSTAT = 4'd5;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

    localparam int ST_CRCERR = 3;
    localparam int ST_RUNT   = 2;
    localparam int ST_ALIGN  = 1;
    localparam int ST_RXERR  = 0;

    typedef enum logic [3:0] {
        RX_IDLE     = 4'd0,
        RX_PREAMBLE = 4'd1,
        RX_DATA     = 4'd2,
        RX_DONE     = 4'd3,
        RX_DISCARD  = 4'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        HIDLE = 2'd0,
        HREAD = 2'd1,
        HWAIT = 2'd2
    } host_state_t;

endpackage

// File: rtl/erx_crc32_nib.sv
// One nibble of the Ethernet CRC-32, bit 0 of the nibble shifted in first.
module erx_crc32_nib
    import ether_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (crc_out[31] ^ nib[i])
                crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
            else
                crc_out = {crc_out[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/erx_mem.sv
// 512x32 frame buffer: registered write, synchronous read that only updates on a read enable.
module erx_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [8:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [0:511];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/ether_rx.sv
// MII receive MAC: preamble strip, nibble packing into a single-frame buffer, FCS/length
// checking, and a cs/cmd/toggle-ready host port to drain the held frame.
module ether_rx
    import ether_pkg::*;
#(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1522,
    parameter int IFG_NIB   = 24
) (
    input  logic        erx_clk,
    input  logic        erx_rst_n,
    input  logic [3:0]  erx_rxd,
    input  logic        erx_dv,
    input  logic        erx_er,
    input  logic        erx_cs,
    input  logic [3:0]  erx_cmd,
    output logic [31:0] erx_data,
    output logic        erx_ready,
    output logic        erx_frame,
    output logic [7:0]  erx_debug
);

    localparam logic [11:0] OVF_NIB = 12'(2 * (MAX_BYTES + 1));

    rx_state_t   state, state_nx;
    host_state_t hstate, hstate_nx;

    logic [7:0]  ifg_cnt;
    logic        ifg_ok;
    logic        dv_q;
    logic [11:0] nib;
    logic [11:0] nib_inc;
    logic [31:0] crc, crc_step;
    logic [31:0] word;
    logic        rxerr;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] bytes;
    logic [3:0]  status;
    logic [7:0]  drop_cnt;
    logic [8:0]  rd_ptr;
    logic [31:0] mem_rdata;
    logic        mem_re;
    logic        release_cmd;

    assign ifg_ok    = (ifg_cnt >= 8'(IFG_NIB));
    assign nib_inc   = nib + 12'd1;
    assign erx_debug = {state, drop_cnt[3:0]};

    erx_crc32_nib crc_step_i (
        .crc_in  (crc),
        .nib     (erx_rxd),
        .crc_out (crc_step)
    );

    erx_mem memory_rx (
        .clk   (erx_clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (mem_re),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // A new preamble is only considered once the buffer is free and the line has been quiet long enough.
    always_comb begin
        state_nx = state;
        case (state)
            RX_IDLE:
                if (!erx_frame && ifg_ok && erx_dv && erx_rxd == 4'b0101)
                    state_nx = RX_PREAMBLE;
            RX_PREAMBLE:
                if (!erx_dv)
                    state_nx = RX_IDLE;
                else if (erx_rxd == 4'b1101)
                    state_nx = RX_DATA;
                else if (erx_rxd != 4'b0101)
                    state_nx = RX_IDLE;
            RX_DATA:
                if (!erx_dv)
                    state_nx = RX_DONE;
                else if (nib_inc >= OVF_NIB)
                    state_nx = RX_DISCARD;
            RX_DONE:
                state_nx = RX_IDLE;
            RX_DISCARD:
                if (!erx_dv)
                    state_nx = RX_IDLE;
            default:
                state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge erx_clk or negedge erx_rst_n) begin
        if (!erx_rst_n) begin
            state     <= RX_IDLE;
            ifg_cnt   <= '0;
            dv_q      <= 1'b0;
            nib       <= '0;
            crc       <= '0;
            word      <= '0;
            rxerr     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bytes     <= '0;
            status    <= '0;
            drop_cnt  <= '0;
            erx_frame <= 1'b0;
        end else begin
            state <= state_nx;
            dv_q  <= erx_dv;
            wr_en <= 1'b0;
            if (erx_dv)
                ifg_cnt <= '0;
            else if (!ifg_ok)
                ifg_cnt <= ifg_cnt + 8'd1;
            if (release_cmd)
                erx_frame <= 1'b0;
            case (state)
                RX_IDLE:
                    if (erx_frame && erx_dv && !dv_q && drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                RX_PREAMBLE: begin
                    crc   <= CRC_INIT;
                    nib   <= '0;
                    word  <= '0;
                    rxerr <= 1'b0;
                end
                RX_DATA:
                    if (erx_dv) begin
                        nib <= nib_inc;
                        crc <= crc_step;
                        if (erx_er)
                            rxerr <= 1'b1;
                        if (nib[2:0] == 3'd7) begin
                            wr_en   <= 1'b1;
                            wr_addr <= nib[11:3];
                            wr_data <= {erx_rxd, word[27:0]};
                            word    <= '0;
                        end else begin
                            word[{nib[2:0], 2'b00} +: 4] <= erx_rxd;
                        end
                    end else if (nib[2:0] != 3'd0) begin
                        // Trailing partial word; upper nibbles are already zero.
                        wr_en   <= 1'b1;
                        wr_addr <= nib[11:3];
                        wr_data <= word;
                    end
                RX_DONE: begin
                    erx_frame <= 1'b1;
                    bytes     <= nib[11:1];
                    status[ST_CRCERR] <= (crc != CRC_RESIDUE);
                    status[ST_RUNT]   <= (nib[11:1] < 11'(MIN_BYTES));
                    status[ST_ALIGN]  <= nib[0];
                    status[ST_RXERR]  <= rxerr;
                end
                RX_DISCARD:
                    if (!erx_dv && drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    // Host side: accept one command per cs assertion, then hold in HWAIT until cs drops.
    always_comb begin
        hstate_nx   = hstate;
        mem_re      = 1'b0;
        release_cmd = 1'b0;
        case (hstate)
            HIDLE:
                if (erx_cs) begin
                    hstate_nx = HWAIT;
                    if (erx_cmd == ERX_CMD_GETDATA && erx_frame) begin
                        hstate_nx = HREAD;
                        mem_re    = 1'b1;
                    end
                    if (erx_cmd == ERX_CMD_RELEASE)
                        release_cmd = 1'b1;
                end
            HREAD:
                hstate_nx = HWAIT;
            HWAIT:
                if (!erx_cs)
                    hstate_nx = HIDLE;
            default:
                hstate_nx = HIDLE;
        endcase
    end

    always_ff @(posedge erx_clk or negedge erx_rst_n) begin
        if (!erx_rst_n) begin
            hstate    <= HIDLE;
            rd_ptr    <= '0;
            erx_data  <= '0;
            erx_ready <= 1'b0;
        end else begin
            hstate <= hstate_nx;
            case (hstate)
                HIDLE:
                    if (erx_cs) begin
                        case (erx_cmd)
                            ERX_CMD_GETSIZE: begin
                                erx_data  <= erx_frame ? {status, 17'b0, bytes} : 32'b0;
                                rd_ptr    <= '0;
                                erx_ready <= ~erx_ready;
                            end
                            ERX_CMD_GETDATA:
                                if (erx_frame) begin
                                    rd_ptr <= rd_ptr + 9'd1;
                                end else begin
                                    erx_data  <= '0;
                                    erx_ready <= ~erx_ready;
                                end
                            ERX_CMD_RELEASE: begin
                                rd_ptr    <= '0;
                                erx_ready <= ~erx_ready;
                            end
                            ERX_CMD_GETSTAT: begin
                                erx_data  <= {24'b0, drop_cnt};
                                erx_ready <= ~erx_ready;
                            end
                            default:
                                erx_ready <= ~erx_ready;
                        endcase
                    end
                HREAD: begin
                    erx_data  <= mem_rdata;
                    erx_ready <= ~erx_ready;
                end
                default: ;
            endcase
        end
    end

endmodule
